uart_tx_packer: RTL and testbench



---
 rtl/uart_tx_packer.sv | 116 +++++++++++
 tb/tb_uart_tx_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_packer.sv
// uart_tx_packer: buffers multi-byte words in a FIFO and hands them LSB byte first to a UART transmitter.
// Optional framing: define UART_TX_PACKER_SYNC_EN to send SYNC_BYTE ahead of every word.
module uart_tx_packer #(
  parameter int         WORD_BYTES = 4,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Word_DV,
  input  logic [8*WORD_BYTES-1:0]       i_Word,
  output logic                          o_Word_Ready,
  output logic                          o_Tx_DV,
  output logic [7:0]                    o_Tx_Byte,
  input  logic                          i_Tx_Active,
  input  logic                          i_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Busy,
  output logic                          o_Overflow
);

  localparam int WORD_W  = 8 * WORD_BYTES;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int FRAME_W = 8 * (WORD_BYTES + 1);
`ifdef UART_TX_PACKER_SYNC_EN
  localparam int FRAME_BYTES = WORD_BYTES + 1;
`else
  localparam int FRAME_BYTES = WORD_BYTES;
`endif
  localparam int            IW       = $clog2(FRAME_BYTES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;
  state_t state, state_next;

  logic [WORD_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic [FRAME_W-1:0] frame, frame_load;
  logic [IW-1:0]      byte_idx;
  logic [7:0]         byte_hold;
  logic               push, pop, tx_dv, last_byte;

  assign o_Word_Ready = (count < CW'(FIFO_DEPTH));
  assign push         = i_Word_DV && o_Word_Ready;
  assign last_byte    = (byte_idx == LAST_IDX);

  // Without framing the sync byte sits in the top slot and is never reached.
`ifdef UART_TX_PACKER_SYNC_EN
  assign frame_load = {mem[rd_ptr], SYNC_BYTE};
`else
  assign frame_load = {SYNC_BYTE, mem[rd_ptr]};
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_next;
  end

  // IDLE also sees this cycle's push so a word into an empty FIFO loads at once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0 || push) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    if (!i_Tx_Active && !i_Tx_Done) state_next = WAIT;
      WAIT:    if (i_Tx_Done) state_next = last_byte ? IDLE : SEND;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    tx_dv = 1'b0;
    if (state == LOAD) pop = 1'b1;
    if (state == SEND && !i_Tx_Active && !i_Tx_Done) tx_dv = 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Word;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
      frame      <= '0;
      byte_idx   <= '0;
      byte_hold  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (i_Word_DV && !o_Word_Ready) o_Overflow <= 1'b1;
      if (tx_dv) byte_hold <= frame[7:0];
      if (pop) begin
        frame    <= frame_load;
        byte_idx <= '0;
      end else if (state == WAIT && i_Tx_Done && !last_byte) begin
        frame    <= frame >> 8;
        byte_idx <= byte_idx + IW'(1);
      end
    end
  end

  // The new byte is visible in the strobe cycle itself and then held until the next strobe.
  assign o_Tx_DV      = tx_dv;
  assign o_Tx_Byte    = tx_dv ? frame[7:0] : byte_hold;
  assign o_Fifo_Count = count;
  assign o_Busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_uart_tx_packer.sv
// Scoreboard bench for uart_tx_packer: a transmitter model answers strobes, a monitor compares bytes.
module tb_uart_tx_packer;
  localparam int         WB    = 4;
  localparam int         DEPTH = 16;
  localparam int         CW    = $clog2(DEPTH) + 1;
  localparam logic [7:0] SYNC  = 8'hA5;
`ifdef UART_TX_PACKER_SYNC_EN
  localparam int FRAME = WB + 1;
`else
  localparam int FRAME = WB;
`endif

  logic          i_Clock = 1'b0;
  logic          i_Reset, i_Word_DV, i_Tx_Active, i_Tx_Done;
  logic [8*WB-1:0] i_Word;
  logic          o_Word_Ready, o_Tx_DV, o_Busy, o_Overflow;
  logic [7:0]    o_Tx_Byte;
  logic [CW-1:0] o_Fifo_Count;

  uart_tx_packer #(.WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Word_DV(i_Word_DV), .i_Word(i_Word),
    .o_Word_Ready(o_Word_Ready), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done), .o_Fifo_Count(o_Fifo_Count),
    .o_Busy(o_Busy), .o_Overflow(o_Overflow)
  );

  always #5 i_Clock = ~i_Clock;

  int         checks = 0, failures = 0;
  logic [7:0] expQ[$];
  logic [7:0] lastByte = 8'h00;
  logic       prevDv = 1'b0;
  bit         monitorOn = 0, stallTx = 0, dvSeen = 0;
  int         strobes = 0, accepted = 0;
  int         minBusy = 1, maxBusy = 4, busyLeft = 0;
  int         injectReq = 0, injectAck = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  function automatic void pushFrame(input logic [8*WB-1:0] w);
`ifdef UART_TX_PACKER_SYNC_EN
    expQ.push_back(SYNC);
`endif
    for (int b = 0; b < WB; b++) expQ.push_back(8'((w >> (8 * b)) & 32'hFF));
  endfunction

  task automatic applyStimulus(input logic [8*WB-1:0] w);
    @(posedge i_Clock); #1;
    i_Word_DV = 1'b1;
    i_Word    = w;
    @(posedge i_Clock); #1;
    i_Word_DV = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    do begin
      @(negedge i_Clock);
      n++;
    end while ((expQ.size() != 0 || o_Busy) && n < 4000);
    checks++;
    if (expQ.size() != 0 || o_Busy) begin
      failures++;
      $display("[TB] FAIL drain_timeout: outstanding=%0d busy=%0b, required 0 and 0", expQ.size(), o_Busy);
    end
    checkOutput("count_after_drain", o_Fifo_Count, 0);
  endtask

  // Transmitter model: busy for a random number of cycles after each strobe, then one Done pulse.
  always @(negedge i_Clock) dvSeen = o_Tx_DV;

  initial begin
    i_Tx_Active = 1'b0;
    i_Tx_Done   = 1'b0;
    forever begin
      @(posedge i_Clock); #1;
      i_Tx_Done = 1'b0;
      if (stallTx) begin
        i_Tx_Active = 1'b1;
      end else if (dvSeen) begin
        busyLeft    = $urandom_range(maxBusy, minBusy);
        i_Tx_Active = 1'b1;
      end else if (busyLeft > 0) begin
        busyLeft--;
        if (busyLeft == 0) begin
          i_Tx_Active = 1'b0;
          i_Tx_Done   = 1'b1;
        end
      end else begin
        i_Tx_Active = 1'b0;
        if (injectReq != injectAck) begin
          i_Tx_Done = 1'b1;
          injectAck++;
        end
      end
    end
  end

  // Monitor: compares every strobe against the scoreboard and records accepted words.
  always @(negedge i_Clock) begin
    if (monitorOn) begin
      if (o_Tx_DV) begin
        checkOutput("dv_while_tx_busy", {i_Tx_Active, i_Tx_Done}, 0);
        checkOutput("dv_back_to_back", prevDv, 0);
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_strobe: got byte %0h, required no strobe", o_Tx_Byte);
        end else begin
          checkOutput("tx_byte", o_Tx_Byte, expQ.pop_front());
        end
        lastByte = o_Tx_Byte;
        strobes++;
      end else begin
        checkOutput("tx_byte_hold", o_Tx_Byte, lastByte);
      end
      prevDv = o_Tx_DV;
      if (i_Reset) begin
        expQ.delete();
        lastByte = 8'h00;
        prevDv   = 1'b0;
      end else if (i_Word_DV && o_Word_Ready) begin
        accepted++;
        pushFrame(i_Word);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, a0, n;
    i_Reset   = 1'b1;
    i_Word_DV = 1'b0;
    i_Word    = '0;
    @(posedge i_Clock); #1;
    monitorOn = 1;
    @(negedge i_Clock);
    checkOutput("reset_dv", o_Tx_DV, 0);
    checkOutput("reset_byte", o_Tx_Byte, 0);
    checkOutput("reset_count", o_Fifo_Count, 0);
    checkOutput("reset_overflow", o_Overflow, 0);
    checkOutput("reset_busy", o_Busy, 0);
    checkOutput("reset_ready", o_Word_Ready, 1);
    @(posedge i_Clock); #1;
    i_Reset = 1'b0;

    $display("[TB] single word, latency and frame length");
    s0 = strobes;
    applyStimulus(32'h44332211);
    @(negedge i_Clock);
    checkOutput("count_after_push", o_Fifo_Count, 1);
    checkOutput("no_early_strobe", o_Tx_DV, 0);
    @(negedge i_Clock);
    checkOutput("first_strobe_latency", o_Tx_DV, 1);
    n = 0;
    while (expQ.size() != 0 && n < 2000) begin @(negedge i_Clock); n++; end
    n = 0;
    while (!i_Tx_Done && n < 50) begin @(negedge i_Clock); n++; end
    checkOutput("last_done_seen", i_Tx_Done, 1);
    @(negedge i_Clock);
    checkOutput("busy_after_last_done", o_Busy, 0);
    checkOutput("frame_strobes", strobes - s0, FRAME);

    $display("[TB] Done pulses while IDLE and SEND");
    s0 = strobes;
    @(negedge i_Clock);
    injectReq++;
    repeat (4) @(negedge i_Clock);
    checkOutput("idle_done_no_strobe", strobes - s0, 0);
    applyStimulus($urandom);
    @(negedge i_Clock);
    injectReq++;
    @(negedge i_Clock);
    checkOutput("send_held_by_done", o_Tx_DV, 0);
    @(negedge i_Clock);
    checkOutput("send_after_done", o_Tx_DV, 1);
    waitDrain();
    checkOutput("send_inject_strobes", strobes - s0, FRAME);

    $display("[TB] overflow with stalled transmitter");
    stallTx = 1;
    a0 = accepted;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(posedge i_Clock); #1;
      i_Word_DV = 1'b1;
      i_Word    = $urandom;
    end
    @(posedge i_Clock); #1;
    i_Word_DV = 1'b0;
    @(negedge i_Clock);
    checkOutput("full_count", o_Fifo_Count, DEPTH);
    checkOutput("full_ready", o_Word_Ready, 0);
    checkOutput("overflow_set", o_Overflow, 1);
    checkOutput("words_accepted", accepted - a0, DEPTH + 1);
    stallTx = 0;
    waitDrain();
    checkOutput("overflow_sticky", o_Overflow, 1);

    $display("[TB] random stream with pointer wrap");
    maxBusy = 3;
    for (int i = 0; i < 160; i++) begin
      @(posedge i_Clock); #1;
      i_Word_DV = ($urandom_range(3, 0) != 0);
      i_Word    = $urandom;
    end
    @(posedge i_Clock); #1;
    i_Word_DV = 1'b0;
    waitDrain();

    $display("[TB] reset during second byte");
    minBusy = 6;
    maxBusy = 10;
    s0 = strobes;
    applyStimulus($urandom);
    n = 0;
    while (strobes < s0 + 2 && n < 200) begin @(negedge i_Clock); n++; end
    checkOutput("reached_second_byte", strobes - s0, 2);
    @(posedge i_Clock); #1;
    i_Reset = 1'b1;
    @(posedge i_Clock); #1;
    i_Reset = 1'b0;
    @(negedge i_Clock);
    checkOutput("post_reset_dv", o_Tx_DV, 0);
    checkOutput("post_reset_byte", o_Tx_Byte, 0);
    checkOutput("post_reset_count", o_Fifo_Count, 0);
    checkOutput("post_reset_overflow", o_Overflow, 0);
    checkOutput("post_reset_busy", o_Busy, 0);
    checkOutput("post_reset_ready", o_Word_Ready, 1);
    s0 = strobes;
    applyStimulus($urandom);
    waitDrain();
    checkOutput("post_reset_strobes", strobes - s0, FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
